// File: rtl/gpr_pkg.sv
// Shared types and helpers for the general-purpose register file and its control unit.
package gpr_pkg;

    typedef enum logic [1:0] {
        WopLoad = 2'd0,
        WopInc  = 2'd1,
        WopDec  = 2'd2,
        WopZero = 2'd3
    } wop_e;

    // Widest register the compute helper supports; callers extend in and truncate out.
    localparam int unsigned MaxWidth = 64;

    function automatic logic [MaxWidth-1:0] wop_compute(
        input wop_e                op,
        input logic [MaxWidth-1:0] cur,
        input logic [MaxWidth-1:0] din
    );
        logic [MaxWidth-1:0] res;
        case (op)
            WopLoad: res = din;
            WopInc:  res = cur + MaxWidth'(1);
            WopDec:  res = cur - MaxWidth'(1);
            default: res = '0;
        endcase
        return res;
    endfunction

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/gpr_if.sv
// Control-unit / write-back side bundle of the register file: write, two reads, reservation.
interface gpr_if
    import gpr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 3
);
    logic             wa;
    wop_e             wop;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] data_in;
    logic             oa;
    logic [AW-1:0]    raddr_a;
    logic [WIDTH-1:0] data_out_a;
    logic             ob;
    logic [AW-1:0]    raddr_b;
    logic [WIDTH-1:0] data_out_b;
    logic             busy_a;
    logic             busy_b;
    logic             rsv;
    logic [AW-1:0]    rsv_addr;
    logic             rsv_ok;

    modport master (
        output wa, wop, waddr, data_in, oa, raddr_a, ob, raddr_b, rsv, rsv_addr,
        input  data_out_a, data_out_b, busy_a, busy_b, rsv_ok
    );

    modport slave (
        input  wa, wop, waddr, data_in, oa, raddr_a, ob, raddr_b, rsv, rsv_addr,
        output data_out_a, data_out_b, busy_a, busy_b, rsv_ok
    );
endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits for in-flight producers; a reservation set beats a write-back clear.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter bit          ZERO_R0 = 1'b0,
    parameter int unsigned AW      = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             rsv,
    input  logic [AW-1:0]    rsv_addr,
    output logic             rsv_ok,
    output logic [DEPTH-1:0] busy
);
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             rsv_busy;

    always_comb begin
        rsv_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_addr == AW'(i)) rsv_busy = busy_q[i];
        end
    end

    assign rsv_ok = rsv & addr_in_range(32'(rsv_addr), DEPTH) & ~rsv_busy
                  & ~(ZERO_R0 && (rsv_addr == '0));

    // Clear first so an accepted reservation on the same register leaves it busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_addr == AW'(i))) busy_d[i] = 1'b0;
            if (rsv_ok && (rsv_addr == AW'(i))) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file: one write port with LOAD/INC/DEC/ZERO, two gated async reads.
module gpr_file
    import gpr_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic  clk,
    input  logic  clr,
    gpr_if.slave  bus
);
    localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] wr_cur, wr_val;
    logic [WIDTH-1:0] rd_a, rd_b;
    logic             busy_rd_a, busy_rd_b;
    logic             wr_ok;
    logic [DEPTH-1:0] busy;

    assign wr_ok = bus.wa & addr_in_range(32'(bus.waddr), DEPTH)
                 & ~(ZERO_R0 && (bus.waddr == '0));

    always_comb begin
        wr_cur = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.waddr == AW'(i)) wr_cur = regs_q[i];
        end
    end

    assign wr_val = WIDTH'(wop_compute(bus.wop, MaxWidth'(wr_cur), MaxWidth'(bus.data_in)));

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (bus.waddr == AW'(i))) regs_d[i] = wr_val;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    gpr_scoreboard #(
        .DEPTH   (DEPTH),
        .ZERO_R0 (ZERO_R0),
        .AW      (AW)
    ) u_scoreboard (
        .clk      (clk),
        .clr      (clr),
        .wr_en    (wr_ok),
        .wr_addr  (bus.waddr),
        .rsv      (bus.rsv),
        .rsv_addr (bus.rsv_addr),
        .rsv_ok   (bus.rsv_ok),
        .busy     (busy)
    );

    // Out-of-range addresses match no entry and fall through to zero / not busy.
    always_comb begin
        rd_a      = '0;
        rd_b      = '0;
        busy_rd_a = 1'b0;
        busy_rd_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.raddr_a == AW'(i)) begin
                busy_rd_a = busy[i];
                if (!(ZERO_R0 && (i == 0))) rd_a = regs_q[i];
            end
            if (bus.raddr_b == AW'(i)) begin
                busy_rd_b = busy[i];
                if (!(ZERO_R0 && (i == 0))) rd_b = regs_q[i];
            end
        end
    end

    assign bus.data_out_a = bus.oa ? rd_a : '0;
    assign bus.data_out_b = bus.ob ? rd_b : '0;
    assign bus.busy_a     = bus.oa & busy_rd_a;
    assign bus.busy_b     = bus.ob & busy_rd_b;

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: default 8x8 instance plus a DEPTH=6, ZERO_R0=1 instance.
module tb_gpr_file;
    import gpr_pkg::*;

    logic clk = 1'b0;
    logic clr;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpr_if #(.WIDTH(8), .AW(3)) bus ();
    gpr_if #(.WIDTH(8), .AW(3)) bus6 ();

    gpr_file #(.WIDTH(8), .DEPTH(8), .ZERO_R0(1'b0)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    gpr_file #(.WIDTH(8), .DEPTH(6), .ZERO_R0(1'b1)) dut6 (
        .clk (clk),
        .clr (clr),
        .bus (bus6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wa = 0;  bus.wop = WopLoad;  bus.waddr = 0;  bus.data_in = 0;
        bus.oa = 0;  bus.raddr_a = 0;  bus.ob = 0;  bus.raddr_b = 0;
        bus.rsv = 0;  bus.rsv_addr = 0;
        bus6.wa = 0;  bus6.wop = WopLoad;  bus6.waddr = 0;  bus6.data_in = 0;
        bus6.oa = 0;  bus6.raddr_a = 0;  bus6.ob = 0;  bus6.raddr_b = 0;
        bus6.rsv = 0;  bus6.rsv_addr = 0;
    endtask

    task automatic test_reset();
        clr = 1;
        tick();
        tick();
        clr = 0;
        bus.oa = 1;
        bus.ob = 1;
        for (int i = 0; i < 8; i++) begin
            bus.raddr_a = 3'(i);
            bus.raddr_b = 3'(7 - i);
            #1;
            checks++;
            if (bus.data_out_a !== 8'h00 || bus.data_out_b !== 8'h00) begin
                errors++;
                $display("FAIL reset_data r%0d: got a=%h b=%h want 00", i, bus.data_out_a,
                         bus.data_out_b);
            end
            checks++;
            if (bus.busy_a !== 1'b0 || bus.busy_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy r%0d: got a=%b b=%b want 0", i, bus.busy_a, bus.busy_b);
            end
        end
        idle();
    endtask

    task automatic test_load_read();
        bus.wa = 1;  bus.wop = WopLoad;  bus.waddr = 3;  bus.data_in = 8'hA5;
        bus.oa = 1;  bus.raddr_a = 3;
        #1;
        checks++;
        if (bus.data_out_a !== 8'h00) begin
            errors++;
            $display("FAIL no_bypass: got %h want 00", bus.data_out_a);
        end
        tick();
        bus.wa = 0;
        bus.ob = 1;  bus.raddr_b = 3;
        #1;
        checks++;
        if (bus.data_out_a !== 8'hA5) begin
            errors++;
            $display("FAIL load_a: got %h want a5", bus.data_out_a);
        end
        checks++;
        if (bus.data_out_b !== 8'hA5) begin
            errors++;
            $display("FAIL load_b_same_addr: got %h want a5", bus.data_out_b);
        end
        bus.oa = 0;
        #1;
        checks++;
        if (bus.data_out_a !== 8'h00) begin
            errors++;
            $display("FAIL oa_gate: got %h want 00", bus.data_out_a);
        end
        idle();
    endtask

    task automatic test_wrap();
        bus.oa = 1;  bus.raddr_a = 2;
        bus.wa = 1;  bus.wop = WopLoad;  bus.waddr = 2;  bus.data_in = 8'hFF;
        tick();
        bus.wop = WopInc;  bus.data_in = 8'h5C;
        tick();
        checks++;
        if (bus.data_out_a !== 8'h00) begin
            errors++;
            $display("FAIL inc_wrap: got %h want 00", bus.data_out_a);
        end
        bus.wop = WopDec;
        tick();
        checks++;
        if (bus.data_out_a !== 8'hFF) begin
            errors++;
            $display("FAIL dec_wrap: got %h want ff", bus.data_out_a);
        end
        bus.wop = WopDec;
        tick();
        checks++;
        if (bus.data_out_a !== 8'hFE) begin
            errors++;
            $display("FAIL dec: got %h want fe", bus.data_out_a);
        end
        bus.wop = WopZero;  bus.waddr = 3;  bus.data_in = 8'h77;  bus.raddr_a = 3;
        tick();
        checks++;
        if (bus.data_out_a !== 8'h00) begin
            errors++;
            $display("FAIL zero_op: got %h want 00", bus.data_out_a);
        end
        idle();
    endtask

    task automatic test_reserve();
        bus.rsv = 1;  bus.rsv_addr = 5;
        #1;
        checks++;
        if (bus.rsv_ok !== 1'b1) begin
            errors++;
            $display("FAIL rsv_accept: got %b want 1", bus.rsv_ok);
        end
        tick();
        bus.ob = 1;  bus.raddr_b = 5;
        #1;
        checks++;
        if (bus.busy_b !== 1'b1) begin
            errors++;
            $display("FAIL rsv_busy: got %b want 1", bus.busy_b);
        end
        checks++;
        if (bus.rsv_ok !== 1'b0) begin
            errors++;
            $display("FAIL rsv_reject_busy: got %b want 0", bus.rsv_ok);
        end
        bus.rsv = 0;
        bus.wa = 1;  bus.wop = WopLoad;  bus.waddr = 5;  bus.data_in = 8'h11;
        tick();
        bus.wa = 0;
        #1;
        checks++;
        if (bus.busy_b !== 1'b0 || bus.data_out_b !== 8'h11) begin
            errors++;
            $display("FAIL writeback: got busy=%b data=%h want busy=0 data=11", bus.busy_b,
                     bus.data_out_b);
        end
        idle();
    endtask

    task automatic test_same_cycle();
        bus.oa = 1;  bus.raddr_a = 4;
        bus.rsv = 1;  bus.rsv_addr = 4;
        bus.wa = 1;  bus.wop = WopLoad;  bus.waddr = 4;  bus.data_in = 8'h22;
        #1;
        checks++;
        if (bus.rsv_ok !== 1'b1) begin
            errors++;
            $display("FAIL same_rsv_ok: got %b want 1", bus.rsv_ok);
        end
        tick();
        bus.rsv = 0;  bus.wa = 0;
        #1;
        checks++;
        if (bus.data_out_a !== 8'h22 || bus.busy_a !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: got data=%h busy=%b want data=22 busy=1", bus.data_out_a,
                     bus.busy_a);
        end
        bus.rsv = 1;  bus.rsv_addr = 4;
        bus.wa = 1;  bus.waddr = 4;  bus.data_in = 8'h33;
        #1;
        checks++;
        if (bus.rsv_ok !== 1'b0) begin
            errors++;
            $display("FAIL busy_rsv_with_write: got %b want 0", bus.rsv_ok);
        end
        tick();
        bus.rsv = 0;  bus.wa = 0;
        #1;
        checks++;
        if (bus.data_out_a !== 8'h33 || bus.busy_a !== 1'b0) begin
            errors++;
            $display("FAIL clear_on_retry: got data=%h busy=%b want data=33 busy=0",
                     bus.data_out_a, bus.busy_a);
        end
        idle();
    endtask

    task automatic test_clear();
        bus.wa = 1;  bus.wop = WopLoad;
        for (int i = 0; i < 8; i++) begin
            bus.waddr = 3'(i);
            bus.data_in = 8'(8'h10 + i);
            tick();
        end
        bus.wa = 0;
        bus.rsv = 1;
        for (int i = 0; i < 3; i++) begin
            bus.rsv_addr = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : 3'd6;
            tick();
        end
        bus.rsv = 0;
        bus.oa = 1;  bus.raddr_a = 6;
        #1;
        checks++;
        if (bus.data_out_a !== 8'h16 || bus.busy_a !== 1'b1) begin
            errors++;
            $display("FAIL prefill: got data=%h busy=%b want data=16 busy=1", bus.data_out_a,
                     bus.busy_a);
        end
        clr = 1;
        bus.wa = 1;  bus.waddr = 7;  bus.data_in = 8'hEE;
        bus.rsv = 1;  bus.rsv_addr = 3;
        tick();
        clr = 0;  bus.wa = 0;  bus.rsv = 0;
        bus.ob = 1;
        for (int i = 0; i < 8; i++) begin
            bus.raddr_a = 3'(i);
            bus.raddr_b = 3'(i);
            #1;
            checks++;
            if (bus.data_out_a !== 8'h00 || bus.busy_a !== 1'b0 || bus.busy_b !== 1'b0) begin
                errors++;
                $display("FAIL clr_r%0d: got data=%h busy=%b want data=00 busy=0", i,
                         bus.data_out_a, bus.busy_a);
            end
        end
        idle();
    endtask

    task automatic test_zero_r0();
        bus6.oa = 1;  bus6.ob = 1;
        bus6.wa = 1;  bus6.wop = WopLoad;  bus6.waddr = 0;  bus6.data_in = 8'h7F;
        tick();
        bus6.waddr = 5;  bus6.data_in = 8'h5A;
        tick();
        bus6.wa = 0;
        bus6.raddr_a = 0;  bus6.raddr_b = 5;
        bus6.rsv = 1;  bus6.rsv_addr = 0;
        #1;
        checks++;
        if (bus6.data_out_a !== 8'h00) begin
            errors++;
            $display("FAIL r0_reads_zero: got %h want 00", bus6.data_out_a);
        end
        checks++;
        if (bus6.data_out_b !== 8'h5A) begin
            errors++;
            $display("FAIL r5_depth6: got %h want 5a", bus6.data_out_b);
        end
        checks++;
        if (bus6.rsv_ok !== 1'b0) begin
            errors++;
            $display("FAIL r0_rsv: got %b want 0", bus6.rsv_ok);
        end
        bus6.rsv_addr = 7;
        #1;
        checks++;
        if (bus6.rsv_ok !== 1'b0) begin
            errors++;
            $display("FAIL oor_rsv: got %b want 0", bus6.rsv_ok);
        end
        bus6.rsv = 0;
        bus6.wa = 1;  bus6.waddr = 7;  bus6.data_in = 8'h99;
        tick();
        bus6.wa = 0;
        bus6.raddr_a = 7;  bus6.raddr_b = 1;
        #1;
        checks++;
        if (bus6.data_out_a !== 8'h00 || bus6.busy_a !== 1'b0) begin
            errors++;
            $display("FAIL oor_read: got data=%h busy=%b want data=00 busy=0", bus6.data_out_a,
                     bus6.busy_a);
        end
        checks++;
        if (bus6.data_out_b !== 8'h00) begin
            errors++;
            $display("FAIL oor_alias_r1: got %h want 00", bus6.data_out_b);
        end
        bus6.rsv = 1;  bus6.rsv_addr = 5;
        #1;
        checks++;
        if (bus6.rsv_ok !== 1'b1) begin
            errors++;
            $display("FAIL r5_rsv_depth6: got %b want 1", bus6.rsv_ok);
        end
        tick();
        idle();
    endtask

    initial begin
        clr = 1;
        idle();
        test_reset();
        test_load_read();
        test_wrap();
        test_reserve();
        test_same_cycle();
        test_clear();
        test_zero_r0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
